// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: widths, control-bundle
// bit positions and instruction field ranges.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // Control bundle layout; ALUOp occupies [CTRL_ALUOP+1:CTRL_ALUOP].
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP    = 0;
  localparam int CTRL_ALUOP_W  = 2;

  localparam int INSTR_W   = 32;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int SHAMT_W   = 5;
  localparam int IMM_W     = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector; purely combinational so the forwarding unit
// can share it later.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_AW_P = REG_AW
) (
  input  logic                id_valid,
  input  logic [REG_AW_P-1:0] id_rs,
  input  logic [REG_AW_P-1:0] id_rt,
  input  logic                ex_valid,
  input  logic                ex_memread,
  input  logic [REG_AW_P-1:0] ex_dest,
  input  logic                flush_in,
  output logic                hazard,
  output logic                stall_out
);

  // A flush kills the ID instruction, so it never needs holding.
  always_comb begin
    hazard    = 1'b0;
    stall_out = 1'b0;
    if (id_valid && ex_valid && ex_memread && (ex_dest != REG_AW_P'(REG_ZERO)) &&
        ((ex_dest == id_rs) || (ex_dest == id_rt))) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
    stall_out = hazard & ~flush_in;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass and load-use bubble
// insertion.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_AW_P = REG_AW,
  parameter int CTRL_W_P = CTRL_W
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic [CTRL_W_P-1:0] id_ctrl,
  input  logic [DATA_W_P-1:0] id_rdata1,
  input  logic [DATA_W_P-1:0] id_rdata2,
  input  logic                wb_regwrite,
  input  logic [REG_AW_P-1:0] wb_waddr,
  input  logic [DATA_W_P-1:0] wb_wdata,
  input  logic                flush_in,
  output logic                stall_out,
  output logic                ex_valid,
  output logic [CTRL_W_P-1:0] ex_ctrl,
  output logic [DATA_W_P-1:0] ex_rdata1,
  output logic [DATA_W_P-1:0] ex_rdata2,
  output logic [DATA_W_P-1:0] ex_imm,
  output logic [4:0]          ex_shamt,
  output logic [REG_AW_P-1:0] ex_rs,
  output logic [REG_AW_P-1:0] ex_rt,
  output logic [REG_AW_P-1:0] ex_dest
);

  logic [REG_AW_P-1:0] rs;
  logic [REG_AW_P-1:0] rt;
  logic [REG_AW_P-1:0] rd;
  logic [REG_AW_P-1:0] dest;
  logic [DATA_W_P-1:0] op1;
  logic [DATA_W_P-1:0] op2;
  logic [DATA_W_P-1:0] imm_ext;
  logic                hazard;
  logic                unused_opcode;

  assign rs            = REG_AW_P'(id_instr[RS_MSB:RS_LSB]);
  assign rt            = REG_AW_P'(id_instr[RT_MSB:RT_LSB]);
  assign rd            = REG_AW_P'(id_instr[RD_MSB:RD_LSB]);
  assign imm_ext       = {{(DATA_W_P-IMM_W){id_instr[IMM_MSB]}}, id_instr[IMM_MSB:IMM_LSB]};
  assign unused_opcode = ^id_instr[OPC_MSB:OPC_LSB];

  // Write-through bypass: $0 always reads zero, even when WB targets it.
  always_comb begin
    op1 = id_rdata1;
    op2 = id_rdata2;
    if (rs == REG_AW_P'(REG_ZERO)) begin
      op1 = '0;
    end else if (wb_regwrite && (wb_waddr == rs)) begin
      op1 = wb_wdata;
    end else begin
      op1 = id_rdata1;
    end
    if (rt == REG_AW_P'(REG_ZERO)) begin
      op2 = '0;
    end else if (wb_regwrite && (wb_waddr == rt)) begin
      op2 = wb_wdata;
    end else begin
      op2 = id_rdata2;
    end
    dest = id_ctrl[CTRL_REGDST] ? rd : rt;
  end

  hazard_detect #(
    .REG_AW_P(REG_AW_P)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs      (rs),
    .id_rt      (rt),
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_dest    (ex_dest),
    .flush_in   (flush_in),
    .hazard     (hazard),
    .stall_out  (stall_out)
  );

  // Pipeline register: flush, hazard and empty ID all produce an all-zero bubble.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_shamt  <= 5'd0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
    end else if (flush_in || hazard || !id_valid) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_shamt  <= 5'd0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
    end else begin
      ex_valid  <= 1'b1;
      ex_ctrl   <= id_ctrl;
      ex_rdata1 <= op1;
      ex_rdata2 <= op2;
      ex_imm    <= imm_ext;
      ex_shamt  <= id_instr[SHAMT_MSB:SHAMT_LSB];
      ex_rs     <= rs;
      ex_rt     <= rt;
      ex_dest   <= dest;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic
// against a behavioural model of the EX-side register contents.
module tb_id_ex_stage;

  logic        CLK;
  logic        RSTn;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [7:0]  id_ctrl;
  logic [31:0] id_rdata1;
  logic [31:0] id_rdata2;
  logic        wb_regwrite;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush_in;
  logic        stall_out;
  logic        ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;

  int tests;
  int errors;

  typedef struct packed {
    logic        v;
    logic [7:0]  ctrl;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
  } ex_t;

  ex_t m;

  id_ex_stage dut (
    .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_instr(id_instr),
    .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush_in(flush_in), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input int opc, input int rs, input int rt, input int imm);
    return {6'(opc), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Register read as seen by EX: $0 is zero, otherwise WB data wins over the file.
  function automatic logic [31:0] ref_op(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (wb_regwrite && wb_waddr == idx) return wb_wdata;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    logic [4:0] rs = id_instr[25:21];
    logic [4:0] rt = id_instr[20:16];
    return id_valid && m.v && m.ctrl[6] && (m.dest != 5'd0) && (m.dest == rs || m.dest == rt);
  endfunction

  function automatic ex_t ref_next();
    ex_t n = '0;
    if (flush_in || ref_hazard() || !id_valid) return n;
    n.v    = 1'b1;
    n.ctrl = id_ctrl;
    n.r1   = ref_op(id_instr[25:21], id_rdata1);
    n.r2   = ref_op(id_instr[20:16], id_rdata2);
    n.imm  = 32'($signed(id_instr[15:0]));
    n.sh   = id_instr[10:6];
    n.rs   = id_instr[25:21];
    n.rt   = id_instr[20:16];
    n.dest = id_ctrl[3] ? id_instr[15:11] : id_instr[20:16];
    return n;
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".ctrl"},  32'(ex_ctrl),  32'(m.ctrl));
    chk({tag, ".r1"},    ex_rdata1,     m.r1);
    chk({tag, ".r2"},    ex_rdata2,     m.r2);
    chk({tag, ".imm"},   ex_imm,        m.imm);
    chk({tag, ".sh"},    32'(ex_shamt), 32'(m.sh));
    chk({tag, ".rs"},    32'(ex_rs),    32'(m.rs));
    chk({tag, ".rt"},    32'(ex_rt),    32'(m.rt));
    chk({tag, ".dest"},  32'(ex_dest),  32'(m.dest));
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag);
    ex_t n;
    #1;
    chk({tag, ".stall"}, 32'(stall_out), 32'(ref_hazard() && !flush_in));
    n = ref_next();
    @(posedge CLK);
    m = n;
    #1;
    check_ex(tag);
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] c,
                       input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_instr = ins; id_ctrl = c; id_rdata1 = d1; id_rdata2 = d2;
  endtask

  localparam logic [7:0] C_ADD  = 8'h8A;
  localparam logic [7:0] C_LW   = 8'hD4;
  localparam logic [7:0] C_ADDI = 8'h84;

  initial begin
    bit hold;
    tests = 0; errors = 0; m = '0;
    RSTn = 1'b0; flush_in = 1'b0;
    wb_regwrite = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    drive(1'b1, mk_r(1, 2, 3, 0), C_ADD, 32'd5, 32'd7);
    repeat (2) @(negedge CLK);
    #1;
    check_ex("reset");
    chk("reset.stall", 32'(stall_out), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    // 1: basic capture
    step("add");
    chk("add.v", 32'(ex_valid), 32'd1);
    chk("add.r1", ex_rdata1, 32'd5);
    chk("add.r2", ex_rdata2, 32'd7);
    chk("add.dest", 32'(ex_dest), 32'd3);

    // 2: write-through and $0
    wb_regwrite = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'hAB;
    drive(1'b1, mk_r(4, 2, 3, 0), C_ADD, 32'h11, 32'd7);
    step("wt");
    chk("wt.r1", ex_rdata1, 32'hAB);
    wb_waddr = 5'd0; wb_wdata = 32'hFF;
    drive(1'b1, mk_r(0, 2, 3, 0), C_ADD, 32'h11, 32'd7);
    step("wt0");
    chk("wt0.r1", ex_rdata1, 32'd0);
    wb_regwrite = 1'b0;

    // 3: load-use, one bubble
    drive(1'b1, mk_i(35, 1, 5, 4), C_LW, 32'h100, 32'd0);
    step("lw5");
    drive(1'b1, mk_r(5, 1, 6, 0), C_ADD, 32'd9, 32'd1);
    #1;
    chk("lu.stall1", 32'(stall_out), 32'd1);
    step("lu.bub");
    chk("lu.bub.v", 32'(ex_valid), 32'd0);
    chk("lu.bub.ctrl", 32'(ex_ctrl), 32'd0);
    #1;
    chk("lu.stall2", 32'(stall_out), 32'd0);
    step("lu.cap");
    chk("lu.cap.v", 32'(ex_valid), 32'd1);
    chk("lu.cap.rs", 32'(ex_rs), 32'd5);

    // 4: no-stall cases
    drive(1'b1, mk_i(35, 1, 0, 4), C_LW, 32'h100, 32'd0);
    step("lw0");
    drive(1'b1, mk_r(0, 0, 6, 0), C_ADD, 32'd0, 32'd0);
    #1;
    chk("lw0.nostall", 32'(stall_out), 32'd0);
    step("use0");
    drive(1'b1, mk_i(35, 1, 5, 4), C_LW, 32'h100, 32'd0);
    step("lw5b");
    drive(1'b1, mk_r(1, 2, 6, 0), C_ADD, 32'd1, 32'd2);
    #1;
    chk("indep.nostall", 32'(stall_out), 32'd0);
    step("indep");

    // 5: flush beats hazard
    drive(1'b1, mk_i(35, 1, 5, 4), C_LW, 32'h100, 32'd0);
    step("lw5c");
    drive(1'b1, mk_r(5, 1, 6, 0), C_ADD, 32'd9, 32'd1);
    flush_in = 1'b1;
    #1;
    chk("fl.stall", 32'(stall_out), 32'd0);
    step("fl");
    chk("fl.v", 32'(ex_valid), 32'd0);
    flush_in = 1'b0;
    drive(1'b1, mk_r(2, 3, 7, 0), C_ADD, 32'd4, 32'd8);
    step("postfl");
    chk("postfl.v", 32'(ex_valid), 32'd1);

    // 6: reset during a stall, then addi sign extension
    drive(1'b1, mk_i(35, 1, 5, 4), C_LW, 32'h100, 32'd0);
    step("lw5d");
    drive(1'b1, mk_r(5, 1, 6, 0), C_ADD, 32'd9, 32'd1);
    #1;
    chk("rs.stall", 32'(stall_out), 32'd1);
    #1;
    RSTn = 1'b0;
    #1;
    m = '0;
    chk("rs.v", 32'(ex_valid), 32'd0);
    chk("rs.stall0", 32'(stall_out), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    drive(1'b1, mk_i(8, 1, 9, 16'hFFFC), C_ADDI, 32'd3, 32'd0);
    step("addi");
    chk("addi.imm", ex_imm, 32'hFFFFFFFC);
    chk("addi.dest", 32'(ex_dest), 32'd9);

    // random traffic; a stalled instruction is re-presented unchanged
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        id_valid  = ($urandom_range(7) != 0);
        id_instr  = {6'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                     5'($urandom_range(7)), 11'($urandom)};
        id_ctrl   = 8'($urandom);
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
      end
      flush_in    = ($urandom_range(9) == 0);
      wb_regwrite = 1'($urandom);
      wb_waddr    = 5'($urandom_range(7));
      wb_wdata    = $urandom;
      hold = ref_hazard() && !flush_in;
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
